// File: rtl/sumador_pkg.sv
// Shared constants for the sumador_completo adder slice.
// Holds the legal operand-width range. The top module checks its WIDTH
// parameter against this range at elaboration.
`timescale 1ns/1ps
package sumador_pkg;
   localparam int MIN_WIDTH = 1;
   localparam int MAX_WIDTH = 64;

   function automatic bit width_is_legal(input int w);
      return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
   endfunction
endpackage

// File: rtl/sumador_completo_full_adder_bit.sv
// One-bit full adder cell. The top module chains these cells into a ripple-carry adder.
// Ports:
//   a, b, ci : operand bits and carry in
//   s, co    : sum bit and carry out
`timescale 1ns/1ps
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   logic w_p;

   assign w_p = a ^ b;
   assign s   = w_p ^ ci;
   assign co  = (a & b) | (ci & w_p);
endmodule

// File: rtl/sumador_completo.sv
// WIDTH-bit ripple-carry adder with an optional registered output stage.
// Ports:
//   ci, b, a  : carry in and operands
//   co, s     : combinational carry out and sum
//   clk       : clock; the register stage updates on its rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : captures the current sum into the register stage
//   s_q, co_q : registered sum and carry out
//   ovf_q     : registered two's-complement overflow flag
//   out_valid : the registers hold a result captured on the previous edge
// When REGISTER_OUT = 0, the register stage is absent and its outputs are tied to 0.
`timescale 1ns/1ps
module sumador_completo
   import sumador_pkg::*;
#(
   parameter int WIDTH        = 1,
   parameter int REGISTER_OUT = 1
) (
   input  logic             ci,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] a,
   output logic             co,
   output logic [WIDTH-1:0] s,
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic [WIDTH-1:0] s_q,
   output logic             co_q,
   output logic             ovf_q,
   output logic             out_valid
);
   generate
      if (!width_is_legal(WIDTH)) begin : g_bad_width
         $error("sumador_completo: WIDTH out of range");
      end
   endgenerate

   // w_carry[i] is the carry into bit i. w_carry[WIDTH] is the carry out of the MSB.
   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic             w_ovf;

   assign w_carry[0] = ci;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         full_adder_bit u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_carry[i]),
            .s  (w_sum[i]),
            .co (w_carry[i+1])
         );
      end
   endgenerate

   assign s  = w_sum;
   assign co = w_carry[WIDTH];
   // Signed overflow occurs when the carry into the MSB differs from the carry out of the MSB.
   assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

   generate
      if (REGISTER_OUT != 0) begin : g_reg
         logic [WIDTH-1:0] r_s_q;
         logic             r_co_q;
         logic             r_ovf_q;
         logic             r_out_valid;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s_q       <= '0;
               r_co_q      <= 1'b0;
               r_ovf_q     <= 1'b0;
               r_out_valid <= 1'b0;
            end else begin
               r_out_valid <= in_valid;
               if (in_valid) begin
                  r_s_q   <= w_sum;
                  r_co_q  <= w_carry[WIDTH];
                  r_ovf_q <= w_ovf;
               end
            end
         end

         assign s_q       = r_s_q;
         assign co_q      = r_co_q;
         assign ovf_q     = r_ovf_q;
         assign out_valid = r_out_valid;
      end else begin : g_noreg
         assign s_q       = '0;
         assign co_q      = 1'b0;
         assign ovf_q     = 1'b0;
         assign out_valid = 1'b0;
      end
   endgenerate
endmodule

// File: tb/tb_sumador_completo.sv
// Directed self-checking bench for sumador_completo.
// It exercises a WIDTH=1 instance (combinational sweep) and a WIDTH=8 instance
// (combinational and registered paths, and reset behaviour).
`timescale 1ns/1ps
module tb_sumador_completo;
   logic       clk;
   logic       rst_n;

   logic       ci1, a1, b1, co1, s1;
   logic       s_q1, co_q1, ovf_q1, out_valid1;
   logic       in_valid1;

   logic       ci8, co8, in_valid8;
   logic [7:0] a8, b8, s8, s_q8;
   logic       co_q8, ovf_q8, out_valid8;

   int n_vec = 0;
   int n_err = 0;

   sumador_completo #(.WIDTH(1), .REGISTER_OUT(1)) u_dut1 (
      .ci(ci1), .b(b1), .a(a1), .co(co1), .s(s1),
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
      .s_q(s_q1), .co_q(co_q1), .ovf_q(ovf_q1), .out_valid(out_valid1)
   );

   sumador_completo #(.WIDTH(8), .REGISTER_OUT(1)) u_dut8 (
      .ci(ci8), .b(b8), .a(a8), .co(co8), .s(s8),
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8),
      .s_q(s_q8), .co_q(co_q8), .ovf_q(ovf_q8), .out_valid(out_valid8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference values for the 8-bit sum and the signed-overflow flag
   function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {8'd0, c};
   endfunction

   function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
      return (a[7] == b[7]) && (s[7] != a[7]);
   endfunction

   initial begin
      logic [1:0] exp1 [8];
      logic [8:0] r;
      exp1[0] = 2'b00; exp1[1] = 2'b01; exp1[2] = 2'b01; exp1[3] = 2'b10;
      exp1[4] = 2'b01; exp1[5] = 2'b10; exp1[6] = 2'b10; exp1[7] = 2'b11;

      rst_n = 1'b0; in_valid1 = 1'b0; in_valid8 = 1'b0;
      ci1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      ci8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      #2;
      check("reset_s_q",       s_q8,       0);
      check("reset_co_q",      co_q8,      0);
      check("reset_ovf_q",     ovf_q8,     0);
      check("reset_out_valid", out_valid8, 0);

      // Sweep all {ci,b,a} combinations on the WIDTH=1 instance
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = i[2:0];
         {ci1, b1, a1} = v;
         #1;
         check($sformatf("w1_sweep_%0d", i), {co1, s1}, exp1[i]);
      end

      step();
      rst_n = 1'b1;

      // Wrap-around: a carry out of the MSB, with no signed overflow
      a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; in_valid8 = 1'b1;
      #1;
      check("wrap_s",  s8,  8'h00);
      check("wrap_co", co8, 1);
      step();
      check("wrap_ovf_q", ovf_q8, 0);
      check("wrap_co_q",  co_q8,  1);

      // Signed overflow with no carry out
      a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0;
      #1;
      check("ovf_s",  s8,  8'h80);
      check("ovf_co", co8, 0);
      step();
      check("ovf_ovf_q", ovf_q8, 1);
      check("ovf_s_q",   s_q8,   8'h80);

      // Capture followed by a hold
      a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1; in_valid8 = 1'b1;
      step();
      check("cap_s_q",       s_q8,       8'h47);
      check("cap_co_q",      co_q8,      0);
      check("cap_out_valid", out_valid8, 1);
      in_valid8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
      step();
      check("hold_s_q",       s_q8,       8'h47);
      check("hold_out_valid", out_valid8, 0);

      // Asynchronous reset pulse between edges while out_valid is high
      a8 = 8'h20; b8 = 8'h03; ci8 = 1'b0; in_valid8 = 1'b1;
      step();
      check("pre_rst_out_valid", out_valid8, 1);
      rst_n = 1'b0;
      #1;
      check("arst_s_q",       s_q8,       0);
      check("arst_co_q",      co_q8,      0);
      check("arst_ovf_q",     ovf_q8,     0);
      check("arst_out_valid", out_valid8, 0);
      a8 = 8'hF0; b8 = 8'h20; ci8 = 1'b1;
      #1;
      check("arst_s_comb",  s8,  8'h11);
      check("arst_co_comb", co8, 1);

      // Reset held across an edge with in_valid high: reset wins
      step();
      check("rst_edge_s_q",       s_q8,       0);
      check("rst_edge_out_valid", out_valid8, 0);
      rst_n = 1'b1;
      a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0;
      step();
      check("first_cap_s_q",       s_q8,       8'h00);
      check("first_cap_co_q",      co_q8,      1);
      check("first_cap_ovf_q",     ovf_q8,     1);
      check("first_cap_out_valid", out_valid8, 1);

      // Back-to-back captures with random operands
      for (int k = 0; k < 16; k++) begin
         a8  = 8'($urandom_range(0, 255));
         b8  = 8'($urandom_range(0, 255));
         ci8 = 1'($urandom_range(0, 1));
         r   = ref_sum(a8, b8, ci8);
         #1;
         check($sformatf("rnd%0d_s", k), {co8, s8}, r);
         step();
         check($sformatf("rnd%0d_s_q", k),   s_q8,       r[7:0]);
         check($sformatf("rnd%0d_co_q", k),  co_q8,      r[8]);
         check($sformatf("rnd%0d_ovf_q", k), ovf_q8,     ref_ovf(a8, b8, r[7:0]));
         check($sformatf("rnd%0d_ov", k),    out_valid8, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sumador_completo.md
SUMADOR_COMPLETO -- requirements
Module: sumador_completo

Parameters
REQ-001 WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 REGISTER_OUT, default 1, 1 = registered output path present, 0 = s_q/co_q/ovf_q/out_valid tied to 0.

Interface
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ci  input  1  carry in.
REQ-006 b  input  WIDTH  operand B.
REQ-007 a  input  WIDTH  operand A.
REQ-008 co  output  1  combinational carry out.
REQ-009 s  output  WIDTH  combinational sum.
REQ-010 in_valid  input  1  qualifies a/b/ci for capture into the registered path.
REQ-011 s_q  output  WIDTH  registered sum.
REQ-012 co_q  output  1  registered carry out.
REQ-013 ovf_q  output  1  registered two's-complement overflow flag.
REQ-014 out_valid  output  1  s_q/co_q/ovf_q hold a result captured on the previous edge.
- Port order on instantiation is ci, b, a, co, s, then the remaining ports; positional instantiation with only the first five ports SHALL remain legal when the others are left unconnected.

Function
REQ-015 {co, s} SHALL equal a + b + ci, computed at WIDTH+1 bits, purely combinational, zero-cycle latency, independent of clk and rst_n.
REQ-016 For WIDTH=1: s = a XOR b XOR ci; co = (a AND b) OR (ci AND (a XOR b)).
REQ-017 Wrap-around: the sum wraps modulo 2^WIDTH, and the carry out of the MSB appears on co.
REQ-018 Carry SHALL ripple LSB to MSB through one full-adder cell per bit; bit i carry-in = bit i-1 carry-out, and bit 0 carry-in = ci.
REQ-019 Overflow ovf = carry into the MSB XOR carry out of the MSB; for WIDTH=1 this is ci XOR co.
REQ-020 On a rising clk edge with in_valid=1: s_q<=s, co_q<=co, ovf_q<=ovf, out_valid<=1; one-cycle latency.
REQ-021 On a rising clk edge with in_valid=0: s_q/co_q/ovf_q hold their values, out_valid<=0.
REQ-022 No backpressure: a new capture is accepted every cycle that in_valid=1.
REQ-023 X/Z on any input SHALL NOT be masked; the outputs propagate it.

Reset
REQ-024 rst_n low SHALL immediately clear s_q, co_q, ovf_q and out_valid to 0, regardless of clk.
REQ-025 The combinational outputs s and co are unaffected by reset.
REQ-026 Reset deasserted mid-stream: the first capture occurs on the first rising edge with rst_n=1 and in_valid=1.
REQ-027 Reset asserted on the same edge as in_valid=1: reset wins, and the outputs stay 0.

Structure
REQ-028 Sub-module full_adder_bit (inputs a, b, ci; outputs s, co) per REQ-016, instantiated WIDTH times via generate.
REQ-029 A shared package sumador_pkg holds the WIDTH legality limits (MIN_WIDTH=1, MAX_WIDTH=64) and an elaboration-time check; no typedefs are required.

Verification
REQ-030 WIDTH=1: sweep all 8 {ci,b,a} combinations 000..111, one step per time unit -> {co,s} = 00,01,01,10,01,10,10,11.
REQ-031 WIDTH=8: a=0xFF, b=0x01, ci=0 -> s=0x00, co=1, ovf=0; a=0x7F, b=0x01, ci=0 -> s=0x80, co=0, ovf=1.
REQ-032 WIDTH=8: in_valid=1 with a=0x12, b=0x34, ci=1 at edge N -> s_q=0x47, co_q=0, out_valid=1 after edge N; in_valid=0 at edge N+1 -> s_q holds 0x47, out_valid=0.
REQ-033 Pulse rst_n low between clock edges while out_valid=1 -> s_q, co_q, ovf_q and out_valid drop to 0 immediately, while s and co still track the inputs.
REQ-034 in_valid=1 held for 16 consecutive cycles with random operands -> each registered result matches the reference sum from one cycle earlier.
